// File: rtl/corr_pkt_framer.sv
// ---------------------------------------------------------------------------
// corr_pkt_framer
//
// Pops 5-byte correlator packets from the packet FIFO and re-emits each one as
// a 7-byte framed record on a valid/ready byte stream:
//    SYNC_BYTE, payload[0..PKT_LEN-1], checksum
// The checksum is chosen so that the payload bytes plus the checksum add up
// to zero (mod 256). Payload byte 0 is the window number. Each window number
// is checked against the previous one, and discontinuities are counted in a
// saturating 8-bit sequence-error counter.
//
// Ports
//    i_clk         clock
//    i_rst_n       asynchronous active-low reset
//    i_cg          clock-gate enable; when low every register holds and no pop
//    i_flush       synchronous abort (shared with the FIFO flush)
//    i_enable      allows a new record to start (sampled only while idle)
//    i_fifo_data   FIFO head byte
//    i_fifo_empty  FIFO empty
//    o_fifo_pop    pop the FIFO head this cycle (combinational)
//    o_data        stream byte (registered)
//    o_valid       stream valid (registered)
//    i_ready       stream ready
//    o_busy        a record is in progress (combinational, state != IDLE)
//    o_nSeqErr     saturating count of window-number sequence errors
// ---------------------------------------------------------------------------
module corr_pkt_framer #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         PKT_LEN   = 5
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_cg,
   input  logic       i_flush,
   input  logic       i_enable,
   input  logic [7:0] i_fifo_data,
   input  logic       i_fifo_empty,
   output logic       o_fifo_pop,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_busy,
   output logic [7:0] o_nSeqErr
);

   localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BODY  = 2'd1,
      CKSUM = 2'd2
   } state_t;

   state_t     stateReg,   stateNext;
   logic [2:0] idxReg,     idxNext;
   logic [7:0] sumReg,     sumNext;
   logic [7:0] lastWinReg, lastWinNext;
   logic       haveLastReg, haveLastNext;
   logic [7:0] nSeqErrReg, nSeqErrNext;
   logic [7:0] dataReg,    dataNext;
   logic       validReg,   validNext;

   // The single output stage can take a new byte when it is empty or when its
   // current byte leaves this cycle.
   logic canLoad;
   logic popNow;
   logic seqBreak;

   assign canLoad = !validReg || i_ready;

   // A window number is in sequence only when it is exactly one more than the
   // previous one; the 8-bit add makes FF -> 00 a legal step.
   assign seqBreak = haveLastReg && (i_fifo_data != 8'(lastWinReg + 8'd1));

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stateReg    <= IDLE;
         idxReg      <= 3'd0;
         sumReg      <= 8'd0;
         lastWinReg  <= 8'd0;
         haveLastReg <= 1'b0;
         nSeqErrReg  <= 8'd0;
         dataReg     <= 8'd0;
         validReg    <= 1'b0;
      end else begin
         stateReg    <= stateNext;
         idxReg      <= idxNext;
         sumReg      <= sumNext;
         lastWinReg  <= lastWinNext;
         haveLastReg <= haveLastNext;
         nSeqErrReg  <= nSeqErrNext;
         dataReg     <= dataNext;
         validReg    <= validNext;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      stateNext    = stateReg;
      idxNext      = idxReg;
      sumNext      = sumReg;
      lastWinNext  = lastWinReg;
      haveLastNext = haveLastReg;
      nSeqErrNext  = nSeqErrReg;
      dataNext     = dataReg;
      validNext    = validReg;

      if (!i_cg) begin
         // Gated: everything holds.
      end else if (i_flush) begin
         // Abort the record and forget the last window: the FIFO is being
         // flushed at the same time, so continuity is meaningless afterwards.
         // The error count survives.
         stateNext    = IDLE;
         validNext    = 1'b0;
         idxNext      = 3'd0;
         sumNext      = 8'd0;
         haveLastNext = 1'b0;
      end else begin
         unique case (stateReg)
            IDLE: begin
               if (i_enable && !i_fifo_empty && canLoad) begin
                  dataNext  = SYNC_BYTE;
                  validNext = 1'b1;
                  sumNext   = 8'd0;
                  idxNext   = 3'd0;
                  stateNext = BODY;
               end else if (canLoad) begin
                  validNext = 1'b0;
               end
            end

            BODY: begin
               if (popNow) begin
                  dataNext  = i_fifo_data;
                  validNext = 1'b1;
                  sumNext   = sumReg + i_fifo_data;
                  idxNext   = idxReg + 3'd1;
                  if (idxReg == 3'd0) begin
                     if (seqBreak && nSeqErrReg != 8'hFF) begin
                        nSeqErrNext = nSeqErrReg + 8'd1;
                     end
                     lastWinNext  = i_fifo_data;
                     haveLastNext = 1'b1;
                  end
                  if (idxReg == LAST_IDX) begin
                     stateNext = CKSUM;
                  end
               end else if (canLoad) begin
                  // FIFO ran dry mid-packet: emit a bubble and wait.
                  validNext = 1'b0;
               end
            end

            CKSUM: begin
               if (canLoad) begin
                  dataNext  = 8'h00 - sumReg;
                  validNext = 1'b1;
                  stateNext = IDLE;
               end
            end

            default: begin
               stateNext = IDLE;
               validNext = 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Output logic
   // -------------------------------------------------------------------------
   always_comb begin
      popNow = i_cg && !i_flush && (stateReg == BODY) && !i_fifo_empty && canLoad;
   end

   assign o_fifo_pop = popNow;
   assign o_busy     = (stateReg != IDLE);
   assign o_data     = dataReg;
   assign o_valid    = validReg;
   assign o_nSeqErr  = nSeqErrReg;

endmodule

// File: tb/tb_corr_pkt_framer.sv
// ---------------------------------------------------------------------------
// Testbench for corr_pkt_framer.
// The reference model treats the FIFO contents as a plain byte stream: every
// PKT_LEN bytes become one expected record (sync, payload, two's-complement
// checksum), and the window-number rule is applied per record to predict the
// error counter. Stream bytes are checked in order as they transfer.
// ---------------------------------------------------------------------------
module tb_corr_pkt_framer;

   localparam logic [7:0] SYNC = 8'hA5;

   logic       clk = 1'b0;
   logic       rstN;
   logic       cg;
   logic       flush;
   logic       enable;
   logic [7:0] fifoData;
   logic       fifoEmpty;
   logic       fifoPop;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       busy;
   logic [7:0] nSeqErr;

   always #5 clk = ~clk;

   corr_pkt_framer #(.SYNC_BYTE(SYNC), .PKT_LEN(5)) dut (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_cg        (cg),
      .i_flush     (flush),
      .i_enable    (enable),
      .i_fifo_data (fifoData),
      .i_fifo_empty(fifoEmpty),
      .o_fifo_pop  (fifoPop),
      .o_data      (data),
      .o_valid     (valid),
      .i_ready     (ready),
      .o_busy      (busy),
      .o_nSeqErr   (nSeqErr)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0] fq[$];     // bytes physically in the FIFO
   logic [7:0] rawQ[$];   // bytes the model has not yet grouped into a record
   logic [7:0] expQ[$];   // expected stream bytes
   logic [7:0] lastM = 8'd0;
   bit         haveLastM = 1'b0;
   int         errM = 0;
   int         popCount = 0;
   int         xferCount = 0;
   bit         prevStall = 1'b0;
   logic [7:0] prevData = 8'd0;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      if (obs !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, req);
      end
   endtask

   function automatic void frameRaw();
      logic [7:0] s;
      logic [7:0] w;
      logic [7:0] b;
      while (rawQ.size() >= 5) begin
         s = 8'd0;
         w = rawQ[0];
         if (haveLastM && w != 8'(lastM + 8'd1)) errM = (errM < 255) ? errM + 1 : 255;
         lastM = w;
         haveLastM = 1'b1;
         expQ.push_back(SYNC);
         for (int k = 0; k < 5; k++) begin
            b = rawQ.pop_front();
            s = s + b;
            expQ.push_back(b);
         end
         expQ.push_back(8'h00 - s);
      end
   endfunction

   function automatic void modelByte(input logic [7:0] b);
      rawQ.push_back(b);
      frameRaw();
   endfunction

   function automatic void pushPkt(input logic [7:0] win);
      logic [7:0] b;
      for (int k = 0; k < 5; k++) begin
         b = (k == 0) ? win : 8'($urandom_range(255));
         fq.push_back(b);
         modelByte(b);
      end
   endfunction

   task automatic driveFifo();
      fifoEmpty = (fq.size() == 0);
      fifoData  = (fq.size() == 0) ? 8'd0 : fq[0];
   endtask

   // One clock cycle: drive at the falling edge, sample 1 ns later, let the
   // rising edge happen, then update the model and return at the next falling edge.
   task automatic step(input logic rdy, input logic fl = 1'b0);
      logic       p;
      logic       x;
      logic [7:0] d;
      ready = rdy;
      flush = fl;
      driveFifo();
      #1;
      p = fifoPop;
      x = valid && ready && cg && !fl;
      d = data;
      if (prevStall) checkVal("holdData", {23'd0, valid, data}, {23'd0, 1'b1, prevData});
      if (valid && !ready) checkVal("stallPop", {31'd0, p}, 32'd0);
      if (!cg) checkVal("cgPop", {31'd0, p}, 32'd0);
      if (fl && cg) checkVal("flushPop", {31'd0, p}, 32'd0);
      prevStall = valid && !ready && !(fl && cg);
      prevData  = d;
      @(posedge clk);
      #1;
      if (fl && cg) begin
         fq.delete();
         rawQ.delete();
         expQ.delete();
         haveLastM = 1'b0;
      end else begin
         if (p) begin
            popCount++;
            if (fq.size() == 0) checkVal("popEmpty", 32'd1, 32'd0);
            else void'(fq.pop_front());
         end
         if (x) begin
            xferCount++;
            if (expQ.size() == 0) checkVal("spuriousByte", {24'd0, d}, 32'hFFFF_FFFF);
            else checkVal("streamByte", {24'd0, d}, {24'd0, expQ.pop_front()});
         end
      end
      flush = 1'b0;
      driveFifo();
      @(negedge clk);
   endtask

   task automatic drain(input int budget, input bit fullRate);
      int n = 0;
      while (expQ.size() > 0 && n < budget) begin
         step(fullRate ? 1'b1 : logic'($urandom_range(3) != 0));
         n++;
      end
      checkVal("drainLeft", expQ.size(), 32'd0);
      step(1'b1);
      checkVal("idleValid", {31'd0, valid}, 32'd0);
      checkVal("idleBusy", {31'd0, busy}, 32'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkVal({tag, "Valid"}, {31'd0, valid}, 32'd0);
      checkVal({tag, "Data"}, {24'd0, data}, 32'd0);
      checkVal({tag, "Pop"}, {31'd0, fifoPop}, 32'd0);
      checkVal({tag, "Busy"}, {31'd0, busy}, 32'd0);
      checkVal({tag, "SeqErr"}, {24'd0, nSeqErr}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] pkt [5];
      logic [8:0] snap;
      logic [7:0] snapD;
      logic [7:0] snapE;
      int base;
      int n;
      logic [7:0] win;

      rstN = 1'b0; cg = 1'b1; flush = 1'b0; enable = 1'b1; ready = 1'b0;
      driveFifo();
      @(negedge clk);
      @(negedge clk);
      checkResetOutputs("reset");
      rstN = 1'b1;
      @(negedge clk);

      // Single packet at full rate: sync one cycle after non-empty, then 7
      // consecutive bytes, exactly 5 pops. Enable dropped mid-record.
      pkt = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h40};
      popCount = 0;
      for (int k = 0; k < 5; k++) begin fq.push_back(pkt[k]); modelByte(pkt[k]); end
      step(1'b1);
      checkVal("latencyValid", {31'd0, valid}, 32'd1);
      checkVal("latencySync", {24'd0, data}, {24'd0, SYNC});
      for (int i = 0; i < 7; i++) begin
         checkVal("consecValid", {31'd0, valid}, 32'd1);
         if (i == 2) enable = 1'b0;
         step(1'b1);
      end
      checkVal("singleDone", expQ.size(), 32'd0);
      checkVal("singlePops", popCount, 32'd5);
      checkVal("singleIdle", {30'd0, valid, busy}, 32'd0);
      checkVal("singleSeqErr", {24'd0, nSeqErr}, 32'd0);

      // Enable low in IDLE: nothing starts.
      pushPkt(8'h04);
      base = popCount;
      repeat (4) step(1'b1);
      checkVal("enableHoldValid", {31'd0, valid}, 32'd0);
      checkVal("enableHoldPops", popCount - base, 32'd0);
      enable = 1'b1;
      drain(50, 1'b1);

      // Backpressure pattern 1,0,0,1.
      pushPkt(8'h05);
      n = 0;
      while (expQ.size() > 0 && n < 100) begin
         step(logic'((n % 4 == 0) || (n % 4 == 3)));
         n++;
      end
      checkVal("bpDone", expQ.size(), 32'd0);
      drain(10, 1'b1);

      // Back-to-back: three packets, 21 bytes in 21 cycles after the first sync load.
      pushPkt(8'h06); pushPkt(8'h07); pushPkt(8'h08);
      base = xferCount;
      repeat (22) step(1'b1);
      checkVal("b2bBytes", xferCount - base, 32'd21);
      drain(10, 1'b1);

      // Sequence gaps, including the legal FF -> 00 wrap.
      pushPkt(8'h0A); pushPkt(8'hFF); pushPkt(8'h00);
      drain(200, 1'b0);
      checkVal("seqGap", {24'd0, nSeqErr}, errM);

      // Underflow bubble: 3 payload bytes now, 2 more after a wait.
      win = 8'(lastM + 8'd1);
      pkt = '{win, 8'h11, 8'h22, 8'h33, 8'h44};
      for (int k = 0; k < 5; k++) modelByte(pkt[k]);
      for (int k = 0; k < 3; k++) fq.push_back(pkt[k]);
      step(1'b1);
      for (int i = 0; i < 12; i++) begin
         step(1'b1);
         checkVal("bubbleBusy", {31'd0, busy}, 32'd1);
      end
      checkVal("bubbleValid", {31'd0, valid}, 32'd0);
      fq.push_back(pkt[3]);
      fq.push_back(pkt[4]);
      drain(50, 1'b1);
      checkVal("bubbleSeqErr", {24'd0, nSeqErr}, errM);

      // Flush after payload byte 2, then an unrelated window number: no error.
      pushPkt(8'h20);
      drain(50, 1'b1);
      snapE = nSeqErr;
      pushPkt(8'h21);
      base = popCount;
      n = 0;
      while (popCount - base < 3 && n < 20) begin step(1'b1); n++; end
      checkVal("flushReach", popCount - base, 32'd3);
      step(1'b0, 1'b1);
      checkVal("flushValid", {31'd0, valid}, 32'd0);
      checkVal("flushBusy", {31'd0, busy}, 32'd0);
      pushPkt(8'h50);
      drain(50, 1'b1);
      checkVal("flushSeqErr", {24'd0, nSeqErr}, {24'd0, snapE});
      checkVal("flushModel", {24'd0, nSeqErr}, errM);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(9) < 2) begin
            win = ($urandom_range(4) == 0) ? 8'($urandom_range(255)) : 8'(lastM + 8'd1);
            pushPkt(win);
         end
         step(logic'($urandom_range(3) != 0));
      end
      drain(2000, 1'b0);
      checkVal("randSeqErr", {24'd0, nSeqErr}, errM);

      // Clock gate mid-record: five frozen cycles, then the record resumes.
      pushPkt(8'($urandom_range(255)));
      pushPkt(8'($urandom_range(255)));
      repeat (3) step(1'b1);
      cg = 1'b0;
      snap  = {valid, data};
      snapD = {7'd0, busy};
      snapE = nSeqErr;
      for (int i = 0; i < 5; i++) begin
         step(1'b1);
         checkVal("cgFrozen", {15'd0, valid, data, 7'd0, busy},
                  {15'd0, snap, snapD});
         checkVal("cgSeqErr", {24'd0, nSeqErr}, {24'd0, snapE});
      end
      cg = 1'b1;
      drain(100, 1'b0);
      checkVal("cgSeqModel", {24'd0, nSeqErr}, errM);

      // Saturation: every packet repeats the same window number.
      for (int i = 0; i < 260; i++) pushPkt(8'h11);
      drain(4000, 1'b1);
      checkVal("seqSat", {24'd0, nSeqErr}, 32'hFF);
      checkVal("seqSatModel", {24'd0, nSeqErr}, errM);

      // Asynchronous reset mid-record; the FIFO residue is re-framed from its head.
      pushPkt(8'h60);
      pushPkt(8'h61);
      repeat (4) step(1'b1);
      rstN = 1'b0;
      #1;
      checkResetOutputs("asyncRst");
      rawQ = fq;
      expQ.delete();
      errM = 0;
      haveLastM = 1'b0;
      prevStall = 1'b0;
      frameRaw();
      @(negedge clk);
      rstN = 1'b1;
      while (rawQ.size() != 0) begin
         win = 8'($urandom_range(255));
         fq.push_back(win);
         modelByte(win);
      end
      drain(100, 1'b1);
      checkVal("rstSeqErr", {24'd0, nSeqErr}, errM);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
